// File: rtl/motor_cmd_scheduler_if.sv
// Byte-stream handshake between the xbee receiver and motor_cmd_scheduler.
// A transfer occurs on a rising edge where rx_valid & rx_ready.
interface motor_cmd_scheduler_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler: decodes two-byte frames (header, value) from the xbee
// receiver into registered duty cycles for the rear motor, front motor and
// steering servo.
// Optional feature: define MOTOR_CMD_WATCHDOG_EN to enable the link-loss
// watchdog that forces failsafe duties after WDOG_CYCLES without a frame.
module motor_cmd_scheduler #(
  parameter logic [31:0] WDOG_CYCLES  = 32'd50_000_000,
  parameter logic [7:0]  SERVO_CENTER = 8'd128
) (
  input  logic                        clk,
  input  logic                        rst,
  motor_cmd_scheduler_if.slave        rx,
  output logic [7:0]                  rear_motor,
  output logic [7:0]                  front_motor,
  output logic [7:0]                  servo,
  output logic                        cmd_err,
  output logic                        wdog_trip
);

  typedef enum logic [1:0] {IDLE, GOT_HDR, APPLY} state_t;

  state_t     state_q, state_d;
  logic       xfer;
  logic       hdr_ok;
  logic       apply;
  logic [1:0] tgt_q;
  logic [7:0] val_q;

  assign xfer   = rx.rx_valid & rx.rx_ready;
  assign hdr_ok = (rx.rx_data[7:4] == 4'hA);
  assign apply  = (state_q == APPLY);

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    rx.rx_ready = 1'b1;
    case (state_q)
      IDLE:    if (xfer && hdr_ok) state_d = GOT_HDR;
      GOT_HDR: if (xfer) state_d = APPLY;
      APPLY: begin
        rx.rx_ready = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch header target and value byte as the frame arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= '0;
      val_q <= '0;
    end else begin
      if (state_q == IDLE && xfer && hdr_ok) tgt_q <= rx.rx_data[1:0];
      if (state_q == GOT_HDR && xfer)        val_q <= rx.rx_data;
    end
  end

  // One-cycle error pulse for a rejected header byte
  always_ff @(posedge clk) begin
    if (rst) cmd_err <= 1'b0;
    else     cmd_err <= (state_q == IDLE) && xfer && !hdr_ok;
  end

`ifdef MOTOR_CMD_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  logic        wdog_expire;

  assign wdog_expire = (wdog_cnt == WDOG_CYCLES - 32'd1);

  // Watchdog counter: cleared by applied frames, saturates at expiry
  always_ff @(posedge clk) begin
    if (rst)               wdog_cnt <= '0;
    else if (apply)        wdog_cnt <= '0;
    else if (!wdog_expire) wdog_cnt <= wdog_cnt + 32'd1;
  end

  // Duty registers and failsafe flag; an apply takes priority over expiry.
  // While saturated, expiry is re-asserted every cycle, holding failsafe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rear_motor  <= '0;
      front_motor <= '0;
      servo       <= SERVO_CENTER;
      wdog_trip   <= 1'b0;
    end else if (apply) begin
      wdog_trip <= 1'b0;
      case (tgt_q)
        2'b00: rear_motor  <= val_q;
        2'b01: front_motor <= val_q;
        2'b10: servo       <= val_q;
        default: begin
          rear_motor  <= val_q;
          front_motor <= val_q;
        end
      endcase
    end else if (wdog_expire) begin
      rear_motor  <= '0;
      front_motor <= '0;
      servo       <= SERVO_CENTER;
      wdog_trip   <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;

  // Duty registers change only on apply or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rear_motor  <= '0;
      front_motor <= '0;
      servo       <= SERVO_CENTER;
    end else if (apply) begin
      case (tgt_q)
        2'b00: rear_motor  <= val_q;
        2'b01: front_motor <= val_q;
        2'b10: servo       <= val_q;
        default: begin
          rear_motor  <= val_q;
          front_motor <= val_q;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed testbench for motor_cmd_scheduler with immediate-assertion checks.
// Watchdog scenarios run only when MOTOR_CMD_WATCHDOG_EN is defined.
module tb_motor_cmd_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] rear_motor, front_motor, servo;
  logic       cmd_err, wdog_trip;

  int n_assert = 0;
  int n_fail   = 0;

  motor_cmd_scheduler_if rx();

  motor_cmd_scheduler #(.WDOG_CYCLES(32'd16), .SERVO_CENTER(8'd128)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rear_motor  (rear_motor),
    .front_motor (front_motor),
    .servo       (servo),
    .cmd_err     (cmd_err),
    .wdog_trip   (wdog_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return #1 after the edge on which it transferred
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    rx.rx_data  = b;
    rx.rx_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rx.rx_ready === 1'b1) done = 1'b1;
      tick();
    end
    rx.rx_valid = 1'b0;
    check("xfer_accepted", {31'd0, done}, 32'd1);
  endtask

  // Full frame; returns one edge after apply so the new duty is settled
  task automatic frame(input logic [7:0] h, input logic [7:0] v);
    send_byte(h);
    send_byte(v);
    tick();
    tick();
  endtask

  logic [7:0] strm [8];
  int idx, lows, cyc;
  logic rdy;

  initial begin
    rx.rx_data  = '0;
    rx.rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_rear",  rear_motor,  8'h00);
    check("rst_front", front_motor, 8'h00);
    check("rst_servo", servo,       8'd128);
    check("rst_err",   cmd_err,     1'b0);
    check("rst_trip",  wdog_trip,   1'b0);
    check("rst_ready", rx.rx_ready, 1'b1);

    // Single-target and dual-target frames
    frame(8'hA0, 8'h64);
    check("a0_rear",  rear_motor,  8'h64);
    check("a0_front", front_motor, 8'h00);
    check("a0_servo", servo,       8'd128);
    frame(8'hA3, 8'h50);
    check("a3_rear",  rear_motor,  8'h50);
    check("a3_front", front_motor, 8'h50);
    check("a3_servo", servo,       8'd128);
    frame(8'hA2, 8'h20);
    check("a2_servo", servo,       8'h20);
    check("a2_rear",  rear_motor,  8'h50);
    check("a2_front", front_motor, 8'h50);

    // Rejected header: one-cycle cmd_err, no duty change
    send_byte(8'h53);
    check("err_pulse", cmd_err,     1'b1);
    check("err_ready", rx.rx_ready, 1'b1);
    tick();
    check("err_clear", cmd_err,    1'b0);
    check("err_rear",  rear_motor, 8'h50);
    check("err_servo", servo,      8'h20);
    frame(8'hA1, 8'h10);
    check("a1_front", front_motor, 8'h10);
    check("a1_rear",  rear_motor,  8'h50);
    // Header bits[3:2] ignored: 8'hAE targets the servo
    frame(8'hAE, 8'h33);
    check("ae_servo", servo,       8'h33);
    check("ae_front", front_motor, 8'h10);

    // Reset mid-frame: following byte is a header and gets rejected
    send_byte(8'hA0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", rx.rx_ready, 1'b1);
    check("midrst_rear",  rear_motor,  8'h00);
    check("midrst_servo", servo,       8'd128);
    send_byte(8'h77);
    check("midrst_err", cmd_err, 1'b1);
    tick();
    tick();
    check("midrst_err_clr", cmd_err,    1'b0);
    check("midrst_rear2",   rear_motor, 8'h00);

    // Reset during APPLY overrides the load
    send_byte(8'hA0);
    send_byte(8'h11);
    check("apply_ready_low", rx.rx_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("applyrst_rear",  rear_motor,  8'h00);
    check("applyrst_ready", rx.rx_ready, 1'b1);
    tick();
    check("applyrst_rear2", rear_motor, 8'h00);

    // Continuous stream with rx_valid held high
    strm = '{8'hA0, 8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03, 8'hA3, 8'h04};
    idx = 0; lows = 0; cyc = 0;
    rx.rx_valid = 1'b1;
    rx.rx_data  = strm[0];
    while (idx < 8 && cyc < 40) begin
      rdy = rx.rx_ready;
      tick();
      cyc++;
      if (rdy) begin
        idx++;
        if (idx < 8) rx.rx_data = strm[idx];
      end else begin
        lows++;
        case (lows)
          1: check("strm_f0_rear",  rear_motor,  8'h01);
          2: check("strm_f1_front", front_motor, 8'h02);
          3: check("strm_f2_servo", servo,       8'h03);
          default: ;
        endcase
      end
    end
    rx.rx_valid = 1'b0;
    check("strm_bytes", idx,  8);
    check("strm_cycles", cyc, 11);
    check("strm_lows",  lows, 3);
    check("strm_last_apply_ready", rx.rx_ready, 1'b0);
    tick();
    check("strm_rear",  rear_motor,  8'h04);
    check("strm_front", front_motor, 8'h04);
    check("strm_servo", servo,       8'h03);

`ifdef MOTOR_CMD_WATCHDOG_EN
    // Expiry after 16 idle cycles, headers do not feed the watchdog
    frame(8'hA2, 8'h44);
    send_byte(8'hA3);
    send_byte(8'h55);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("wd_pre_trip", wdog_trip,  1'b0);
    check("wd_pre_rear", rear_motor, 8'h55);
    tick();
    check("wd_trip",  wdog_trip,   1'b1);
    check("wd_rear",  rear_motor,  8'h00);
    check("wd_front", front_motor, 8'h00);
    check("wd_servo", servo,       8'd128);
    send_byte(8'hA0);
    tick(); tick(); tick();
    check("wd_hdr_only_trip", wdog_trip, 1'b1);
    send_byte(8'h30);
    tick();
    check("wd_recover_trip",  wdog_trip,   1'b0);
    check("wd_recover_rear",  rear_motor,  8'h30);
    check("wd_recover_front", front_motor, 8'h00);
    check("wd_recover_servo", servo,       8'd128);

    // Apply and expiry on the same edge: apply wins, counter restarts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    send_byte(8'hA0);
    send_byte(8'h66);
    tick();
    check("wd_coinc_trip", wdog_trip,  1'b0);
    check("wd_coinc_rear", rear_motor, 8'h66);
    for (int i = 0; i < 15; i++) tick();
    check("wd_restart_trip", wdog_trip, 1'b0);
    tick();
    check("wd_restart_expire", wdog_trip, 1'b1);
`else
    // Without the watchdog duties hold indefinitely
    for (int i = 0; i < 40; i++) tick();
    check("nowd_trip",  wdog_trip,   1'b0);
    check("nowd_rear",  rear_motor,  8'h04);
    check("nowd_servo", servo,       8'h03);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
